exu_result_buffer: RTL

Result queue between the ALU and the register-file writeback port. Captures each valid ALU result with its destination register and PC-write flag, then holds it in a small circular FIFO until the writeback stage accepts it with a valid/ready handshake. Also provides a same-cycle forwarding lookup so that issue logic can bypass results still waiting for writeback. A flush input discards every buffered entry on a pipeline redirect.

---
 rtl/exu_result_buffer_if.sv | 54 +++++
 rtl/exu_result_buffer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/exu_result_buffer_if.sv
// -----------------------------------------------------------------------------
// exu_result_buffer_if
//   Bus bundle for the ALU-to-writeback result buffer.
//   Signal names keep their _i/_o suffixes as seen from the buffer.
//
//   Push side   : valid_i, result_i, enable_pc_write_i, rd_addr_i
//   Control     : flush_i
//   Status      : full_o, empty_o, overflow_o
//   Writeback   : wb_valid_o, wb_ready_i, wb_data_o, wb_addr_o, wb_pc_write_o
//   Forwarding  : fwd_addr_i, fwd_hit_o, fwd_data_o
//
//   Modports: slave  = the buffer itself
//             master = its surroundings (ALU, writeback stage, issue logic)
// -----------------------------------------------------------------------------
interface exu_result_buffer_if #(
    parameter int XLEN     = 32,
    parameter int REG_ADDR = 5
) ();
    logic                flush_i;
    logic                valid_i;
    logic [XLEN-1:0]     result_i;
    logic                enable_pc_write_i;
    logic [REG_ADDR-1:0] rd_addr_i;

    logic                full_o;
    logic                empty_o;
    logic                overflow_o;

    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [XLEN-1:0]     wb_data_o;
    logic [REG_ADDR-1:0] wb_addr_o;
    logic                wb_pc_write_o;

    logic [REG_ADDR-1:0] fwd_addr_i;
    logic                fwd_hit_o;
    logic [XLEN-1:0]     fwd_data_o;

    modport slave (
        input  flush_i, valid_i, result_i, enable_pc_write_i, rd_addr_i,
        input  wb_ready_i, fwd_addr_i,
        output full_o, empty_o, overflow_o,
        output wb_valid_o, wb_data_o, wb_addr_o, wb_pc_write_o,
        output fwd_hit_o, fwd_data_o
    );

    modport master (
        output flush_i, valid_i, result_i, enable_pc_write_i, rd_addr_i,
        output wb_ready_i, fwd_addr_i,
        input  full_o, empty_o, overflow_o,
        input  wb_valid_o, wb_data_o, wb_addr_o, wb_pc_write_o,
        input  fwd_hit_o, fwd_data_o
    );
endinterface

// File: rtl/exu_result_buffer.sv
// -----------------------------------------------------------------------------
// exu_result_buffer
//   Circular FIFO that queues ALU results until the register-file writeback
//   port accepts them (valid/ready). It also offers a combinational forwarding
//   lookup over the buffered entries, youngest match wins, and a flush that
//   drops every entry on a pipeline redirect.
//
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - synchronous active-high reset
//     bus    - exu_result_buffer_if.slave (push, writeback, forwarding, status)
// -----------------------------------------------------------------------------
module exu_result_buffer #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int REG_ADDR = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    exu_result_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]     result;
        logic [REG_ADDR-1:0] rd_addr;
        logic                pc_write;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Flags depend on registered count only, so no input reaches them
    // combinationally.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.valid_i && !full;
    assign pop   = !empty && bus.wb_ready_i;

    // Pointer / count / overflow state.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst_i) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.flush_i) begin
            // Redirect: drop everything, ignore this cycle's push/pop,
            // keep the sticky overflow flag as it is.
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Full is judged on the registered flag, so a pop in the same
            // cycle does not rescue the push.
            if (bus.valid_i && full) overflow <= 1'b1;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately not reset; occupancy is
        // tracked by count, so stale contents are never observed.
        if (!rst_i && !bus.flush_i && push) begin
            mem[wptr] <= '{result:   bus.result_i,
                           rd_addr:  bus.rd_addr_i,
                           pc_write: bus.enable_pc_write_i};
        end
    end

    // Head of queue; forced to zero when empty so no stale data leaks out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        bus.wb_data_o     = '0;
        bus.wb_addr_o     = '0;
        bus.wb_pc_write_o = 1'b0;
        if (!empty) begin
            bus.wb_data_o     = mem[rptr].result;
            bus.wb_addr_o     = mem[rptr].rd_addr;
            bus.wb_pc_write_o = mem[rptr].pc_write;
        end
    end

    // Forwarding lookup: walk occupied slots from oldest to youngest so that
    // the last match (the youngest producer) is what remains. x0 never hits.
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.fwd_hit_o  = 1'b0;
        bus.fwd_data_o = '0;
        idx            = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (bus.fwd_addr_i != '0) &&
                (mem[idx].rd_addr == bus.fwd_addr_i)) begin
                bus.fwd_hit_o  = 1'b1;
                bus.fwd_data_o = mem[idx].result;
            end
        end
    end

    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.overflow_o = overflow;
    assign bus.wb_valid_o = !empty;

endmodule
